// File: rtl/simd_operand_sequencer.sv
// SIMD operand sequencer: feeds the FPU two-operand input register one lane
// pair at a time, collects each lane result into a packed result vector and
// reports completion, abort or watchdog timeout to the control block.
module simd_operand_sequencer #(
    parameter int LANES   = 4,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       simd_start,
    input  logic                       simd_abort,
    input  logic [LANES*DATA_W-1:0]    vec_a,
    input  logic [LANES*DATA_W-1:0]    vec_b,
    input  logic                       fpu_done,
    input  logic [DATA_W-1:0]          fpu_result,
    output logic [DATA_W-1:0]          fpu_operand_a,
    output logic [DATA_W-1:0]          fpu_operand_b,
    output logic                       simd_doorbell,
    output logic [LANES*DATA_W-1:0]    vec_result,
    output logic [$clog2(LANES)-1:0]   lane_idx,
    output logic                       simd_busy,
    output logic                       simd_done,
    output logic                       simd_error
);

    localparam int VW   = LANES * DATA_W;
    localparam int LW   = $clog2(LANES);
    localparam int WD_W = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LAST   = WD_W'(TIMEOUT - 1);
    localparam logic [LW-1:0]   LANE_LAST = LW'(LANES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [VW-1:0]   shadow_a;
    logic [VW-1:0]   shadow_b;
    logic [WD_W-1:0] watchdog;
    logic [LW-1:0]   lane_nxt;
    logic            last_lane;
    logic            wd_expired;

    // Pick one DATA_W lane out of a packed lane vector.
    function automatic logic [DATA_W-1:0] lane_sel(input logic [VW-1:0] v,
                                                   input logic [LW-1:0] idx);
        return v[int'(idx)*DATA_W +: DATA_W];
    endfunction

    assign last_lane  = (lane_idx == LANE_LAST);
    assign wd_expired = (watchdog == WD_LAST);
    assign lane_nxt   = lane_idx + LW'(1);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode plus the single-cycle strobes owned by ISSUE and DONE.
    always_comb begin
        state_nxt     = state;
        simd_doorbell = 1'b0;
        simd_done     = 1'b0;
        case (state)
            IDLE: begin
                if (simd_start) begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                simd_doorbell = 1'b1;
                state_nxt     = simd_abort ? IDLE : WAIT;
            end
            WAIT: begin
                // Abort outranks a result arriving in the same cycle.
                if (simd_abort) begin
                    state_nxt = IDLE;
                end else if (fpu_done) begin
                    state_nxt = last_lane ? DONE : ISSUE;
                end else if (wd_expired) begin
                    state_nxt = IDLE;
                end
            end
            DONE: begin
                simd_done = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Shadow vectors, operand registers, lane index, watchdog, result packing and status flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            shadow_a      <= '0;
            shadow_b      <= '0;
            fpu_operand_a <= '0;
            fpu_operand_b <= '0;
            vec_result    <= '0;
            lane_idx      <= '0;
            watchdog      <= '0;
            simd_busy     <= 1'b0;
            simd_error    <= 1'b0;
        end else begin
            simd_busy <= (state_nxt != IDLE);
            case (state)
                IDLE: begin
                    if (simd_start) begin
                        // Operands are loaded straight from the inputs so lane 0
                        // is already valid in the first ISSUE cycle.
                        shadow_a      <= vec_a;
                        shadow_b      <= vec_b;
                        fpu_operand_a <= vec_a[DATA_W-1:0];
                        fpu_operand_b <= vec_b[DATA_W-1:0];
                        lane_idx      <= '0;
                        simd_error    <= 1'b0;
                    end
                end
                ISSUE: begin
                    watchdog <= '0;
                end
                WAIT: begin
                    watchdog <= watchdog + WD_W'(1);
                    if (!simd_abort) begin
                        if (fpu_done) begin
                            vec_result[int'(lane_idx)*DATA_W +: DATA_W] <= fpu_result;
                            if (!last_lane) begin
                                lane_idx      <= lane_nxt;
                                fpu_operand_a <= lane_sel(shadow_a, lane_nxt);
                                fpu_operand_b <= lane_sel(shadow_b, lane_nxt);
                            end
                        end else if (wd_expired) begin
                            simd_error <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
